// File: rtl/soc_system_addr_scan_pkg.sv
// soc_system_addr_scan_pkg: register offsets, CTRL/STATUS bit positions and FSM states for the address scanner
package soc_system_addr_scan_pkg;
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_RANGE    = 3'd2;
  localparam logic [2:0] REG_SETTLE   = 3'd3;
  localparam logic [2:0] REG_MANUAL   = 3'd4;
  localparam logic [2:0] REG_SUM      = 3'd5;
  localparam logic [2:0] REG_MAX      = 3'd6;
  localparam logic [2:0] REG_MAX_ADDR = 3'd7;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;
endpackage

// File: rtl/soc_system_addr_scan_if.sv
// soc_system_addr_scan_if: Avalon-MM slave bus (address, chipselect, write_n, writedata, readdata) with master/slave modports
interface soc_system_addr_scan_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_addr_scan_acc.sv
// soc_system_addr_scan_acc: running sum / strict maximum / address of maximum accumulator (ports clk, reset_n, clear, capture, data_in, cur, sum, max_val, max_addr)
module soc_system_addr_scan_acc (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        capture,
  input  logic [31:0] data_in,
  input  logic [7:0]  cur,
  output logic [31:0] sum,
  output logic [31:0] max_val,
  output logic [7:0]  max_addr
);
  logic first;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sum      <= '0;
      max_val  <= '0;
      max_addr <= '0;
      first    <= 1'b0;
    end else if (clear) begin
      sum      <= '0;
      max_val  <= '0;
      max_addr <= '0;
      first    <= 1'b1;
    end else if (capture) begin
      sum   <= sum + data_in;
      first <= 1'b0;
      if (first || data_in > max_val) begin
        max_val  <= data_in;
        max_addr <= cur;
      end
    end
endmodule

// File: rtl/soc_system_addr_scan.sv
// soc_system_addr_scan: Avalon-MM address scanner driving out_port (ports clk, reset_n, bus slave, data_in, out_port, irq; IRQ_EN/irq present only with SOC_SYSTEM_ADDR_SCAN_IRQ_EN)
module soc_system_addr_scan
  import soc_system_addr_scan_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  soc_system_addr_scan_if.slave        bus,
  input  logic [31:0]                  data_in,
  output logic [7:0]                   out_port,
  output logic                         irq
);
  logic        we, wr_ctrl, wr_stat, wr_range, wr_settle, wr_manual;
  logic        start, abort, busy, capture, clear, last_hit, done, irq_en;
  logic [15:0] range_r;
  logic [7:0]  settle_r, manual_r, manual_nx, cur, last_s, settle_s, cnt, max_addr;
  logic [31:0] sum, max_val;
  state_t      state;
  assign we        = bus.chipselect && !bus.write_n;
  assign wr_ctrl   = we && bus.address == REG_CTRL;
  assign wr_stat   = we && bus.address == REG_STATUS;
  assign wr_range  = we && bus.address == REG_RANGE;
  assign wr_settle = we && bus.address == REG_SETTLE;
  assign wr_manual = we && bus.address == REG_MANUAL;
  assign abort     = wr_ctrl && bus.writedata[CTRL_ABORT];
  assign start     = wr_ctrl && bus.writedata[CTRL_START] && !bus.writedata[CTRL_ABORT];
  assign manual_nx = wr_manual ? bus.writedata[7:0] : manual_r;
  assign busy      = state != IDLE;
  assign capture   = state == CAPTURE && !abort;
  assign last_hit  = capture && cur == last_s;
  assign clear     = state == IDLE && start;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      range_r  <= '0;
      settle_r <= '0;
      manual_r <= '0;
    end else begin
      if (wr_range) range_r <= bus.writedata[15:0];
      if (wr_settle) settle_r <= bus.writedata[7:0];
      manual_r <= manual_nx;
    end
`ifdef SOC_SYSTEM_ADDR_SCAN_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= bus.writedata[CTRL_IRQ_EN];
      irq <= done && irq_en;
    end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif
  // out_port tracks MANUAL (including a same-cycle MANUAL write) whenever the FSM is or returns to IDLE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cur      <= '0;
      last_s   <= '0;
      settle_s <= '0;
      cnt      <= '0;
      out_port <= '0;
      done     <= 1'b0;
    end else begin
      done <= last_hit || (done && !(wr_stat && bus.writedata[STAT_DONE]));
      case (state)
        IDLE:
          if (start) begin
            last_s   <= range_r[15:8];
            settle_s <= settle_r;
            cur      <= range_r[7:0];
            out_port <= range_r[7:0];
            cnt      <= settle_r;
            state    <= SETTLE;
          end else out_port <= manual_nx;
        SETTLE:
          if (abort) begin
            state    <= IDLE;
            out_port <= manual_nx;
          end else if (cnt == 8'd0) state <= CAPTURE;
          else cnt <= cnt - 8'd1;
        CAPTURE:
          if (abort || last_hit) begin
            state    <= IDLE;
            out_port <= manual_nx;
          end else begin
            cur      <= cur + 8'd1;
            out_port <= cur + 8'd1;
            cnt      <= settle_s;
            state    <= SETTLE;
          end
        default: state <= IDLE;
      endcase
    end
  soc_system_addr_scan_acc u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .capture  (capture),
    .data_in  (data_in),
    .cur      (cur),
    .sum      (sum),
    .max_val  (max_val),
    .max_addr (max_addr)
  );
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      REG_CTRL:     bus.readdata[CTRL_IRQ_EN] = irq_en;
      REG_STATUS:   bus.readdata[STAT_DONE:STAT_BUSY] = {done, busy};
      REG_RANGE:    bus.readdata[15:0] = range_r;
      REG_SETTLE:   bus.readdata[7:0] = settle_r;
      REG_MANUAL:   bus.readdata[7:0] = manual_r;
      REG_SUM:      bus.readdata = sum;
      REG_MAX:      bus.readdata = max_val;
      REG_MAX_ADDR: bus.readdata[7:0] = max_addr;
      default:      bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_soc_system_addr_scan.sv
// tb_soc_system_addr_scan: directed scoreboard bench for soc_system_addr_scan
module tb_soc_system_addr_scan;
  typedef struct {string name; int kind; logic [31:0] exp;} exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode = 1'b0;
  logic        strobe = 1'b0;
  int          kind = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] data_in, act;
  logic [7:0]  out_port;
  logic        irq;
  exp_t        q[$];
  exp_t        e;
  soc_system_addr_scan_if bus();
  soc_system_addr_scan dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .data_in  (data_in),
    .out_port (out_port),
    .irq      (irq)
  );
  always #5 clk = ~clk;
  assign data_in = mode ? 32'd7 : {24'd0, out_port} * 32'd10;
  always @(negedge clk)
    if (strobe) begin
      if (q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: output presented with no expected value queued");
      end else begin
        e = q.pop_front();
        act = e.kind == 0 ? bus.readdata : e.kind == 1 ? {24'd0, out_port} : {31'd0, irq};
        checks++;
        if (act !== e.exp) begin
          fails++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int k, input logic [31:0] x);
    q.push_back('{n, k, x});
    kind = k;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic rd(input string n, input logic [2:0] a, input logic [31:0] x);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b1;
    chk(n, 0, x);
    bus.chipselect = 1'b0;
  endtask
  localparam logic [31:0] IRQ_HI = `ifdef SOC_SYSTEM_ADDR_SCAN_IRQ_EN 32'd1 `else 32'd0 `endif;
  initial begin
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    tick();
    chk("por_out_port", 1, 0);
    chk("por_irq", 2, 0);
    reset_n = 1'b1;
    tick();
    wr(3'd4, 32'hA5);
    chk("manual_out_port", 1, 32'hA5);
    rd("manual_readback", 3'd4, 32'hA5);
    wr(3'd2, 32'h0503);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'h1);
    chk("scan_port_3", 1, 3);
    rd("scan_busy", 3'd1, 32'h1);
    repeat (2) tick();
    chk("scan_port_4", 1, 4);
    repeat (3) tick();
    chk("scan_port_5", 1, 5);
    repeat (2) tick();
    rd("scan_busy_last", 3'd1, 32'h1);
    rd("scan_done", 3'd1, 32'h2);
    rd("scan_sum", 3'd5, 32'd120);
    rd("scan_max", 3'd6, 32'd50);
    rd("scan_max_addr", 3'd7, 32'd5);
    chk("scan_port_manual", 1, 32'hA5);
    chk("scan_irq_off", 2, 0);
    wr(3'd1, 32'h2);
    mode = 1'b1;
    wr(3'd2, 32'h01FE);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'h1);
    chk("wrap_port_fe", 1, 32'hFE);
    repeat (5) tick();
    chk("wrap_port_01", 1, 32'h01);
    tick();
    rd("wrap_done", 3'd1, 32'h2);
    rd("wrap_sum", 3'd5, 32'd28);
    rd("wrap_max", 3'd6, 32'd7);
    rd("wrap_max_addr", 3'd7, 32'hFE);
    wr(3'd1, 32'h2);
    rd("w1c_done", 3'd1, 32'h0);
    wr(3'd3, 32'd10);
    wr(3'd2, 32'h0503);
    wr(3'd0, 32'h1);
    wr(3'd2, 32'h0907);
    wr(3'd0, 32'h1);
    chk("restart_ignored", 1, 3);
    rd("abort_busy_before", 3'd1, 32'h1);
    wr(3'd0, 32'h2);
    rd("abort_status", 3'd1, 32'h0);
    chk("abort_port_manual", 1, 32'hA5);
    rd("abort_sum_partial", 3'd5, 32'd0);
    rd("range_stored", 3'd2, 32'h0907);
    wr(3'd0, 32'h3);
    rd("start_abort_idle", 3'd1, 32'h0);
    chk("start_abort_port", 1, 32'hA5);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'h0202);
    wr(3'd0, 32'h4);
    rd("ctrl_irq_en", 3'd0, IRQ_HI << 2);
    wr(3'd0, 32'h5);
    tick();
    wr(3'd1, 32'h2);
    chk("irq_lag", 2, 0);
    chk("irq_set", 2, IRQ_HI);
    rd("done_set_wins", 3'd1, 32'h2);
    rd("one_addr_sum", 3'd5, 32'd7);
    wr(3'd1, 32'h2);
    tick();
    chk("irq_cleared", 2, 0);
    rd("done_cleared", 3'd1, 32'h0);
    wr(3'd0, 32'h5);
    repeat (3) tick();
    chk("pre_reset_irq", 2, IRQ_HI);
    wr(3'd3, 32'd10);
    wr(3'd0, 32'h5);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_out_port", 1, 0);
    chk("rst_irq", 2, 0);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_reg%0d", i), 3'(i), 32'h0);
    reset_n = 1'b1;
    tick();
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected values left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
